// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI command controller and RAM arbiter.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } pend_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPI_ACC  = 2'd1,
    HOST_ACC = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_cmd_decode.sv
// Decodes SPI slave words: rx_valid edge detect, address registers,
// the single pending memory command and the sticky overflow flag.
module spi_cmd_decode
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  input  logic              pend_clr,
  output logic              rx_stb,
  output logic [1:0]        pend,
  output logic [DATA_W-1:0] pend_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              spi_ovf
);

  logic  rx_valid_d;
  pend_t pend_q;
  logic  busy;

  assign rx_stb = rx_valid & ~rx_valid_d;
  assign pend   = pend_q;
  // A command being taken by the arbiter this cycle is not an overflow.
  assign busy   = (pend_q != NONE) && !pend_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d <= 1'b0;
      pend_q     <= NONE;
      pend_data  <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      spi_ovf    <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      if (pend_clr) pend_q <= NONE;
      if (rx_stb) begin
        case (rx_data[9:8])
          OP_WR_ADDR: wr_addr <= rx_data[ADDR_W-1:0];
          OP_WR_DATA: begin
            pend_q    <= WR;
            pend_data <= rx_data[DATA_W-1:0];
            if (busy) spi_ovf <= 1'b1;
          end
          OP_RD_ADDR: rd_addr <= rx_data[ADDR_W-1:0];
          OP_RD_DATA: begin
            pend_q <= RD;
            if (busy) spi_ovf <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between SPI commands (fixed priority)
// and a local host; returns read data to the SPI slave or the host.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              spi_ovf
);

  state_t            state;
  logic              owner_spi;
  logic              rx_stb;
  logic [1:0]        pend_bits;
  pend_t             pend;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              pend_clr;

  assign pend     = pend_t'(pend_bits);
  assign pend_clr = (state == IDLE) && (pend != NONE);

  spi_cmd_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_decode (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pend_clr  (pend_clr),
    .rx_stb    (rx_stb),
    .pend      (pend_bits),
    .pend_data (pend_data),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .spi_ovf   (spi_ovf)
  );

  // RAM controls are registered on the IDLE exit edge so they are live
  // exactly during SPI_ACC / HOST_ACC; mem_we then selects the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_spi   <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      host_gnt    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      if (rx_stb) tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pend != NONE) begin
            state     <= SPI_ACC;
            owner_spi <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= (pend == WR);
            mem_addr  <= (pend == WR) ? wr_addr : rd_addr;
            mem_wdata <= pend_data;
          end else if (host_req) begin
            state     <= HOST_ACC;
            owner_spi <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= host_we;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            host_gnt  <= 1'b1;
          end
        end
        SPI_ACC, HOST_ACC: state <= mem_we ? IDLE : RD_WAIT;
        RD_WAIT: begin
          if (owner_spi) begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
          end else begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
